// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared lift scheduler types, floor limits and floor mask helpers
package lift_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [2:0] F_FST = 3'd1;
  localparam logic [2:0] F_LST = 3'd7;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    DOWN   = 2'b01,
    UP     = 2'b10,
    UPDOWN = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DOOR,
    DECIDE
  } sched_state_t;

  function automatic logic [7:1] floor_bit(input logic [2:0] f);
    return {f == 3'd7, f == 3'd6, f == 3'd5, f == 3'd4, f == 3'd3, f == 3'd2, f == 3'd1};
  endfunction

  // Floors strictly above / strictly below f.
  function automatic logic [7:1] above_mask(input logic [2:0] f);
    return {f < 3'd7, f < 3'd6, f < 3'd5, f < 3'd4, f < 3'd3, f < 3'd2, 1'b0};
  endfunction

  function automatic logic [7:1] below_mask(input logic [2:0] f);
    return {1'b0, f > 3'd6, f > 3'd5, f > 3'd4, f > 3'd3, f > 3'd2, f > 3'd1};
  endfunction

endpackage

// File: rtl/lift_door_timer.sv
// rtl/lift_door_timer.sv - door hold counter: load, decrement while running, expire on last count
module lift_door_timer
  import lift_pkg::*;
#(
  parameter int unsigned DOOR_HOLD_CLK = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic done
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= DOOR_HOLD_CLK;
    end else if (run && count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  // A reload in the final cycle wins over expiry.
  assign done = run && !load && (count == 32'd1);

endmodule

// File: rtl/lift_scheduler.sv
// rtl/lift_scheduler.sv - car-side lift scheduler: call lamps, floor tracking, direction and door FSM
// Optional LIFT_DOOR_REOPEN_EN: adds doorOpenBtn and lets the door hold be restarted.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned DOOR_HOLD_CLK = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:1] hallUpReq,
  input  logic [7:1] hallDownReq,
  input  logic [7:1] carReq,
  input  logic [2:0] nextFloor,
  input  logic       move,
`ifdef LIFT_DOOR_REOPEN_EN
  input  logic       doorOpenBtn,
`endif
  output logic [2:0] currentFloor,
  output logic [1:0] currentDirection,
  output logic       doorState,
  output logic [7:1] upLamp,
  output logic [7:1] downLamp,
  output logic [7:1] carLamp
);

  sched_state_t state_q, state_d;
  dir_t         dir_q, dir_d, last_q, last_d;
  logic         door_d, move_d, load, run, done, open_btn, reload;
  logic         in_door, here, any_above, any_below, arrive, stop_up, stop_dn;
  logic [7:1]   f_bit, blk, up_v, dn_v, eff, up_clr, dn_clr, car_clr;

  // No up call exists at the top floor, no down call at the bottom.
  always_comb begin
    up_v    = hallUpReq;
    up_v[7] = 1'b0;
    dn_v    = hallDownReq;
    dn_v[1] = 1'b0;
  end

  assign in_door   = (state_q == DOOR);
  assign run       = in_door;
  assign f_bit     = floor_bit(currentFloor);
  assign eff       = upLamp | downLamp | carLamp | up_v | dn_v | carReq;
  assign here      = |(eff & f_bit);
  assign any_above = |(eff & above_mask(currentFloor));
  assign any_below = |(eff & below_mask(currentFloor));
  assign arrive    = move_d && !move;
  assign stop_up   = |((carLamp | upLamp) & f_bit) || (currentFloor == F_LST) || !any_above;
  assign stop_dn   = |((carLamp | downLamp) & f_bit) || (currentFloor == F_FST) || !any_below;

`ifdef LIFT_DOOR_REOPEN_EN
  assign open_btn = doorOpenBtn;
  assign reload   = in_door && (doorOpenBtn || |((up_v | dn_v | carReq) & f_bit));
`else
  assign open_btn = 1'b0;
  assign reload   = 1'b0;
`endif

  // Calls for the floor the car is idling or standing open at are served, never latched.
  assign blk     = (state_q == IDLE || in_door) ? f_bit : '0;
  assign car_clr = in_door ? f_bit : '0;
  assign up_clr  = (in_door && (last_q != DOWN || !any_below)) ? f_bit : '0;
  assign dn_clr  = (in_door && (last_q != UP || !any_above)) ? f_bit : '0;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    door_d  = doorState;
    load    = reload;
    unique case (state_q)
      IDLE: begin
        if (here || open_btn) begin
          state_d = DOOR;
          dir_d   = STOP;
          last_d  = STOP;
          door_d  = ON;
          load    = 1'b1;
        end else if (any_above) begin
          state_d = RUN;
          dir_d   = UP;
        end else if (any_below) begin
          state_d = RUN;
          dir_d   = DOWN;
        end else begin
          dir_d = STOP;
        end
      end
      RUN: begin
        if (arrive && ((dir_q == UP) ? stop_up : stop_dn)) begin
          state_d = DOOR;
          dir_d   = STOP;
          last_d  = dir_q;
          door_d  = ON;
          load    = 1'b1;
        end
      end
      DOOR: begin
        if (done) begin
          door_d  = OFF;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (last_q == DOWN) begin
          dir_d = any_below ? DOWN : (any_above ? UP : STOP);
        end else begin
          dir_d = any_above ? UP : (any_below ? DOWN : STOP);
        end
        state_d = (dir_d == STOP) ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dir_q        <= STOP;
      last_q       <= STOP;
      doorState    <= OFF;
      move_d       <= 1'b0;
      currentFloor <= F_FST;
      upLamp       <= '0;
      downLamp     <= '0;
      carLamp      <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      last_q    <= last_d;
      doorState <= door_d;
      move_d    <= move;
      // A mover starting while the door is open is a protocol error and is ignored.
      if (move && !doorState) begin
        currentFloor <= nextFloor;
      end
      upLamp   <= (upLamp | (up_v & ~blk)) & ~up_clr;
      downLamp <= (downLamp | (dn_v & ~blk)) & ~dn_clr;
      carLamp  <= (carLamp | (carReq & ~blk)) & ~car_clr;
    end
  end

  assign currentDirection = dir_q;

  lift_door_timer #(
    .DOOR_HOLD_CLK(DOOR_HOLD_CLK)
  ) u_door_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .run  (run),
    .done (done)
  );

endmodule

// File: tb/tb_lift_scheduler.sv
// tb/tb_lift_scheduler.sv - directed self-checking bench for lift_scheduler (DOOR_HOLD_CLK=4)
module tb_lift_scheduler;

  localparam int unsigned HOLD = 4;
  localparam int CLK_PER_MOVE = 8;
  localparam logic [7:1] B0 = 7'b0000000;
  localparam logic [7:1] B1 = 7'b0000001;
  localparam logic [7:1] B2 = 7'b0000010;
  localparam logic [7:1] B3 = 7'b0000100;
  localparam logic [7:1] B4 = 7'b0001000;
  localparam logic [7:1] B6 = 7'b0100000;
  localparam logic [7:1] B7 = 7'b1000000;
  localparam logic [1:0] D_STOP = 2'b00;
  localparam logic [1:0] D_UP   = 2'b10;
  localparam logic [1:0] D_DOWN = 2'b01;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] hallUpReq, hallDownReq, carReq;
  logic [2:0] nextFloor;
  logic       move;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection;
  logic       doorState;
  logic [7:1] upLamp, downLamp, carLamp;
`ifdef LIFT_DOOR_REOPEN_EN
  logic       doorOpenBtn;
`endif

  int errors = 0;
  int checks = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  lift_scheduler #(.DOOR_HOLD_CLK(HOLD)) dut (
    .clk             (clk),
    .reset           (reset),
    .hallUpReq       (hallUpReq),
    .hallDownReq     (hallDownReq),
    .carReq          (carReq),
    .nextFloor       (nextFloor),
    .move            (move),
`ifdef LIFT_DOOR_REOPEN_EN
    .doorOpenBtn     (doorOpenBtn),
`endif
    .currentFloor    (currentFloor),
    .currentDirection(currentDirection),
    .doorState       (doorState),
    .upLamp          (upLamp),
    .downLamp        (downLamp),
    .carLamp         (carLamp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:1] up, input logic [7:1] dn, input logic [7:1] car);
    hallUpReq   = up;
    hallDownReq = dn;
    carReq      = car;
    @(negedge clk);
    hallUpReq   = '0;
    hallDownReq = '0;
    carReq      = '0;
  endtask

  // Mover travels one floor; returns at the sample point after the arrival is registered.
  task automatic hop(input logic [2:0] to);
    nextFloor = to;
    move      = 1'b1;
    repeat (CLK_PER_MOVE) @(negedge clk);
    move = 1'b0;
    @(negedge clk);
  endtask

  task automatic door_cycles(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20 && doorState === 1'b1; i++) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    hallUpReq = '0; hallDownReq = '0; carReq = '0;
    nextFloor = 3'd1; move = 1'b0;
`ifdef LIFT_DOOR_REOPEN_EN
    doorOpenBtn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_floor", currentFloor, 3'd1);
    check("rst_dir", currentDirection, D_STOP);
    check("rst_door", doorState, 1'b0);
    check("rst_lamps", {upLamp, downLamp, carLamp}, 21'd0);
    reset = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (currentFloor !== 3'd1 || currentDirection !== D_STOP || doorState !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // Call at the idle car's floor opens the door one clock later.
    pulse(B0, B0, B1);
    check("f1_door_on", doorState, 1'b1);
    check("f1_carlamp", carLamp, B0);
    door_cycles(n);
    check("f1_door_clks", n, HOLD);
    @(negedge clk);
    check("f1_dir_idle", currentDirection, D_STOP);

    // Car call to 4 from 1.
    pulse(B0, B0, B4);
    check("c4_dir", currentDirection, D_UP);
    check("c4_lamp", carLamp, B4);
    hop(3'd2);
    check("c4_pass2_door", doorState, 1'b0);
    check("c4_pass2_dir", currentDirection, D_UP);
    hop(3'd3);
    check("c4_pass3_door", doorState, 1'b0);
    check("c4_pass3_floor", currentFloor, 3'd3);
    hop(3'd4);
    check("c4_stop_door", doorState, 1'b1);
    check("c4_stop_dir", currentDirection, D_STOP);
    check("c4_stop_floor", currentFloor, 3'd4);
    door_cycles(n);
    check("c4_door_clks", n, HOLD);
    check("c4_lamp_clr", carLamp, B0);
    @(negedge clk);
    check("c4_dir_idle", currentDirection, D_STOP);

    // From 4: down call at 2 plus car call at 6 -> 6 first, then reverse to 2.
    pulse(B0, B2, B6);
    check("rv_dir_up", currentDirection, D_UP);
    check("rv_carlamp", carLamp, B6);
    check("rv_dnlamp", downLamp, B2);
    hop(3'd5);
    check("rv_pass5_door", doorState, 1'b0);
    hop(3'd6);
    check("rv_stop6_door", doorState, 1'b1);
    door_cycles(n);
    check("rv_door6_clks", n, HOLD);
    @(negedge clk);
    check("rv_dir_down", currentDirection, D_DOWN);
    check("rv_carlamp_clr", carLamp, B0);
    check("rv_dnlamp_kept", downLamp, B2);
    hop(3'd5);
    hop(3'd4);
    hop(3'd3);
    check("rv_pass3_door", doorState, 1'b0);
    check("rv_pass3_dir", currentDirection, D_DOWN);
    hop(3'd2);
    check("rv_stop2_door", doorState, 1'b1);
    check("rv_stop2_floor", currentFloor, 3'd2);
    door_cycles(n);
    check("rv_door2_clks", n, HOLD);
    @(negedge clk);
    check("rv_dnlamp_clr", downLamp, B0);
    check("rv_dir_idle", currentDirection, D_STOP);

    // Up call at top floor and down call at bottom floor are meaningless.
    pulse(B7, B1, B0);
    check("ign_uplamp", upLamp, B0);
    check("ign_dnlamp", downLamp, B0);
    check("ign_dir", currentDirection, D_STOP);

    // Down call at 7 from 2: car must stop at 7 and never show UP there.
    pulse(B0, B7, B0);
    check("top_dir", currentDirection, D_UP);
    for (int f = 3; f <= 6; f++) begin
      hop(3'(f));
      check("top_pass_dir", currentDirection, D_UP);
    end
    hop(3'd7);
    check("top_stop_door", doorState, 1'b1);
    check("top_stop_dir", currentDirection, D_STOP);
    door_cycles(n);
    check("top_door_clks", n, HOLD);
    @(negedge clk);
    check("top_dir_idle", currentDirection, D_STOP);
    check("top_floor", currentFloor, 3'd7);
    check("top_dnlamp_clr", downLamp, B0);

    // Asynchronous reset in the middle of a move.
    pulse(B0, B0, B3);
    check("mr_dir", currentDirection, D_DOWN);
    nextFloor = 3'd6;
    move = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mr_floor", currentFloor, 3'd1);
    check("mr_dir_rst", currentDirection, D_STOP);
    check("mr_door", doorState, 1'b0);
    check("mr_carlamp", carLamp, B0);
    move = 1'b0;
    nextFloor = 3'd1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_after_dir", currentDirection, D_STOP);

`ifdef LIFT_DOOR_REOPEN_EN
    // Door open button in the last hold count restarts the full hold.
    pulse(B0, B0, B1);
    check("ro_door_on", doorState, 1'b1);
    repeat (3) @(negedge clk);
    doorOpenBtn = 1'b1;
    @(negedge clk);
    doorOpenBtn = 1'b0;
    door_cycles(n);
    check("ro_more_clks", n, HOLD);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
